// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
// Signed support in div_seq_ctrl is enabled with the DIV_SIGNED_EN macro.
package div_pkg;

    localparam int DIV_REG_SIZE = 32;
    localparam int DIV_CNT_W    = $clog2(DIV_REG_SIZE) + 1;
    localparam int DIV_LATENCY  = DIV_REG_SIZE + 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    function automatic int div_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/div_nr_step.sv
// One combinational non-restoring division step.
// The partial remainder is (W+1)-bit two's complement.
module div_nr_step #(
    parameter int W = 32
) (
    input  logic [W:0]   i_p,
    input  logic         i_q_msb,
    input  logic [W-1:0] i_d,
    output logic [W:0]   o_p_new,
    output logic         o_q_bit
);

    logic [W:0] w_s;
    logic [W:0] w_d;

    assign w_s = {i_p[W-1:0], i_q_msb};
    assign w_d = {1'b0, i_d};

    // Intermediate wrap of w_s is harmless: the true result always fits.
    assign o_p_new = i_p[W] ? (w_s + w_d) : (w_s - w_d);
    assign o_q_bit = ~o_p_new[W];

endmodule

// File: rtl/div_seq_ctrl.sv
// Start/busy/done sequencer around the non-restoring divide step.
// Define DIV_SIGNED_EN to add the signed_op port and sign handling.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int REG_SIZE = DIV_REG_SIZE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [REG_SIZE-1:0] dividend,
    input  logic [REG_SIZE-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic                signed_op,
`endif
    output logic                busy,
    output logic                done,
    output logic [REG_SIZE-1:0] quotient,
    output logic [REG_SIZE-1:0] remainder,
    output logic                div_by_zero
);

    localparam int CNT_W = div_cnt_w(REG_SIZE);

    div_state_e r_state;
    div_state_e w_next;

    logic [REG_SIZE:0]   r_p;
    logic [REG_SIZE-1:0] r_q;
    logic [REG_SIZE-1:0] r_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [REG_SIZE-1:0] r_quo;
    logic [REG_SIZE-1:0] r_rem;
    logic                r_dbz;
    logic                r_busy;
    logic                r_done;

    logic                w_d_zero;
    logic                w_last;
    logic [REG_SIZE:0]   w_p_new;
    logic                w_q_bit;
    logic [REG_SIZE-1:0] w_p_fix;
    logic [REG_SIZE-1:0] w_dvd_mag;
    logic [REG_SIZE-1:0] w_dvs_mag;
    logic [REG_SIZE-1:0] w_quo_fix;
    logic [REG_SIZE-1:0] w_rem_fix;

    assign w_d_zero = (divisor == '0);
    assign w_last   = (r_cnt == CNT_W'(REG_SIZE - 1));

    div_nr_step #(
        .W(REG_SIZE)
    ) u_step (
        .i_p     (r_p),
        .i_q_msb (r_q[REG_SIZE-1]),
        .i_d     (r_d),
        .o_p_new (w_p_new),
        .o_q_bit (w_q_bit)
    );

    // Corrected remainder is always below D, so REG_SIZE bits suffice.
    assign w_p_fix = r_p[REG_SIZE] ? (r_p[REG_SIZE-1:0] + r_d)
                                   : r_p[REG_SIZE-1:0];

`ifdef DIV_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_neg = signed_op & dividend[REG_SIZE-1];
    assign w_dvs_neg = signed_op & divisor[REG_SIZE-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;
    // MIN / -1 needs no special case: |MIN| / 1 negated wraps back to MIN.
    assign w_quo_fix = r_neg_q ? (~r_q + 1'b1) : r_q;
    assign w_rem_fix = r_neg_r ? (~w_p_fix + 1'b1) : w_p_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
    assign w_quo_fix = r_q;
    assign w_rem_fix = w_p_fix;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = w_d_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next = FIX;
                end
            end
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_q   <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dbz <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_p   <= '0;
                        r_q   <= w_dvd_mag;
                        r_d   <= w_dvs_mag;
                        r_cnt <= '0;
                        if (w_d_zero) begin
                            r_quo <= '1;
                            r_rem <= dividend;
                            r_dbz <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_p   <= w_p_new;
                    r_q   <= {r_q[REG_SIZE-2:0], w_q_bit};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    r_p   <= {1'b0, w_p_fix};
                    r_quo <= w_quo_fix;
                    r_rem <= w_rem_fix;
                    r_dbz <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: vector table plus handshake/reset cases.
// Signed vectors are added when DIV_SIGNED_EN is defined.
module tb_div_seq_ctrl;
    import div_pkg::*;

    localparam int W = DIV_REG_SIZE;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic         sop;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
        logic         exp_z;
        int           exp_lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
`ifdef DIV_SIGNED_EN
    logic         signed_op = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_err = 0;
    int lat;
    int pulses;
    int busy_bad;
    logic [W-1:0] cap_q;
    logic [W-1:0] cap_r;
    logic         cap_z;
    vec_t tbl[$];

    div_seq_ctrl #(.REG_SIZE(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller sits at a negedge; start is sampled at the next posedge (T0).
    // Cycle k is observed at the negedge following edge T(k-1).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj1, input int inj2);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat      = 0;
        pulses   = 0;
        busy_bad = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            start = (k == inj1) || (k == inj2);
            if (start) begin
                dividend = 32'hDEAD_BEEF;
                divisor  = 32'h0000_0003;
            end
            if (lat != 0 && k == lat + 1) begin
                check("idle_busy", W'(busy), '0);
                check("idle_done", W'(done), '0);
                break;
            end
            if (!busy) busy_bad++;
            if (done) begin
                pulses++;
                if (lat == 0) begin
                    lat   = k;
                    cap_q = quotient;
                    cap_r = remainder;
                    cap_z = div_by_zero;
                end
            end
        end
        if (lat == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL timeout: no done within 80 cycles");
        end
    endtask

    initial begin
        tbl.push_back('{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34});
        tbl.push_back('{32'hFFFF_FFFF, 32'd1, 1'b0,
                        32'hFFFF_FFFF, 32'd0, 1'b0, 34});
        tbl.push_back('{32'd5, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd5, 1'b0, 34});
        tbl.push_back('{32'd42, 32'd0, 1'b0,
                        32'hFFFF_FFFF, 32'd42, 1'b1, 1});
        tbl.push_back('{32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34});
        tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
                        32'd1, 32'd0, 1'b0, 34});
        tbl.push_back('{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 34});
        tbl.push_back('{32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 34});
        tbl.push_back('{32'h8000_0000, 32'd3, 1'b0,
                        32'h2AAA_AAAA, 32'd2, 1'b0, 34});
`ifdef DIV_SIGNED_EN
        tbl.push_back('{32'hFFFF_FFF9, 32'd2, 1'b1,
                        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34});
        tbl.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                        32'h8000_0000, 32'd0, 1'b0, 34});
        tbl.push_back('{32'd7, 32'hFFFF_FFFE, 1'b1,
                        32'hFFFF_FFFD, 32'd1, 1'b0, 34});
        tbl.push_back('{32'hFFFF_FFFB, 32'd0, 1'b1,
                        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1});
`endif

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_q", quotient, '0);
        check("rst_r", remainder, '0);
        check("rst_dbz", W'(div_by_zero), '0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
`ifdef DIV_SIGNED_EN
            signed_op = tbl[i].sop;
`endif
            do_op(tbl[i].dvd, tbl[i].dvs, 0, 0);
            check($sformatf("v%0d_lat", i), W'(lat), W'(tbl[i].exp_lat));
            check($sformatf("v%0d_pulses", i), W'(pulses), W'(1));
            check($sformatf("v%0d_busy", i), W'(busy_bad), '0);
            check($sformatf("v%0d_q", i), cap_q, tbl[i].exp_q);
            check($sformatf("v%0d_r", i), cap_r, tbl[i].exp_r);
            check($sformatf("v%0d_dbz", i), W'(cap_z), W'(tbl[i].exp_z));
            check($sformatf("v%0d_q_hold", i), quotient, tbl[i].exp_q);
        end
`ifdef DIV_SIGNED_EN
        signed_op = 1'b0;
`endif

        // Starts at T5 and during DONE (T34) must be dropped.
        do_op(32'd100, 32'd7, 5, 34);
        check("inj_lat", W'(lat), W'(DIV_LATENCY));
        check("inj_pulses", W'(pulses), W'(1));
        check("inj_q", cap_q, 32'd14);
        check("inj_r", cap_r, 32'd2);
        // Start at T35 (first IDLE cycle) is accepted.
        do_op(32'd9, 32'd3, 0, 0);
        check("t35_lat", W'(lat), W'(DIV_LATENCY));
        check("t35_q", cap_q, 32'd3);
        check("t35_r", cap_r, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("no_queue", W'(pulses), '0);

        // Asynchronous reset in the middle of CALC.
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", W'(busy), W'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", W'(busy), '0);
        check("arst_done", W'(done), '0);
        check("arst_q", quotient, '0);
        check("arst_r", remainder, '0);
        check("arst_dbz", W'(div_by_zero), '0);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) pulses++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("arst_no_done", W'(pulses), '0);
        do_op(32'd20, 32'd6, 0, 0);
        check("post_rst_lat", W'(lat), W'(DIV_LATENCY));
        check("post_rst_q", cap_q, 32'd3);
        check("post_rst_r", cap_r, 32'd2);
        check("post_rst_dbz", W'(cap_z), '0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
